// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the round-robin bus arbiter:
//   - arb_state_e          : arbiter FSM state encoding
//   - ARB_MAX_HOLD_DEFAULT : default hold limit for a non-locked grant
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GRANT  = 2'b01,
    ARB_LOCKED = 2'b10
  } arb_state_e;

  localparam int ARB_MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin winner selection. Finds the first candidate
//   bit scanning upward from rr_ptr (wrapping SIZE-1 -> 0), where the
//   candidates are req with the exclude mask cleared.
// Ports:
//   req     in  SIZE       request vector
//   rr_ptr  in  SEL_WIDTH  index where the scan starts
//   exclude in  SIZE       bits removed from consideration
//   found   out 1          a candidate exists
//   index   out SEL_WIDTH  binary index of the winner (0 if none)
//   onehot  out SIZE       one-hot winner (all zero if none)
module rr_priority_pick #(
  parameter  int SIZE      = 4,
  localparam int SEL_WIDTH = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]      req,
  input  logic [SEL_WIDTH-1:0] rr_ptr,
  input  logic [SIZE-1:0]      exclude,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] index,
  output logic [SIZE-1:0]      onehot
);

  logic [SIZE-1:0]      cand;
  logic [SIZE-1:0]      rotated;
  logic [SEL_WIDTH-1:0] rot_index;

  assign cand = req & ~exclude;

  // Rotate so that bit rr_ptr lands at position 0. SIZE is a power of two,
  // so the SEL_WIDTH-bit sum wraps modulo SIZE for free.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_rotate
      logic [SEL_WIDTH-1:0] src_idx;
      assign src_idx     = SEL_WIDTH'(gi) + rr_ptr;
      assign rotated[gi] = cand[src_idx];
    end
  endgenerate

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    found     = 1'b0;
    rot_index = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found     = 1'b1;
        rot_index = SEL_WIDTH'(i);
      end
    end
  end

  // Un-rotate back to an absolute index (again wrapping modulo SIZE).
  assign index = found ? (rot_index + rr_ptr) : '0;

  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_onehot
      assign onehot[gi] = found && (index == SEL_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter for SIZE bus masters sharing one data bus. Produces
//   a registered one-hot grant, the binary select for the downstream N:1
//   data switch, and bounds how long a non-locked owner may keep the bus
//   while others wait.
// Ports:
//   clk       in  1          system clock, rising edge
//   reset_n   in  1          asynchronous active-low reset
//   req       in  SIZE       per-master request, level sensitive
//   lock      in  SIZE       per-master lock, honoured only for the owner
//   grant     out SIZE       one-hot grant (registered)
//   sel       out SEL_WIDTH  binary owner index for the switch (registered)
//   bus_valid out 1          a grant is active (registered)
//   preempt   out 1          one-cycle pulse on a forced handoff (registered)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int SIZE      = 4,
  parameter  int MAX_HOLD  = ARB_MAX_HOLD_DEFAULT,
  localparam int SEL_WIDTH = $clog2(SIZE),
  localparam int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SIZE-1:0]      req,
  input  logic [SIZE-1:0]      lock,
  output logic [SIZE-1:0]      grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 bus_valid,
  output logic                 preempt
);

  arb_state_e           state_reg, state_next;
  logic [SEL_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_WIDTH-1:0] hold_cnt_reg, hold_cnt_next;
  logic [SIZE-1:0]      grant_reg, grant_next;
  logic [SEL_WIDTH-1:0] sel_reg, sel_next;
  logic                 bus_valid_reg;
  logic                 preempt_reg, preempt_next;

  // Winner search. While idle the scan starts at rr_ptr; while a grant is
  // active it starts just past the owner and skips the owner, which is
  // exactly the pointer the ending grant would leave behind.
  logic [SEL_WIDTH-1:0] pick_ptr;
  logic [SIZE-1:0]      pick_exclude;
  logic                 pick_found;
  logic [SEL_WIDTH-1:0] pick_index;
  logic [SIZE-1:0]      pick_onehot;

  assign pick_ptr     = (state_reg == ARB_IDLE) ? rr_ptr_reg : sel_reg + SEL_WIDTH'(1);
  assign pick_exclude = (state_reg == ARB_IDLE) ? '0 : grant_reg;

  rr_priority_pick #(
    .SIZE(SIZE)
  ) u_pick (
    .req     (req),
    .rr_ptr  (pick_ptr),
    .exclude (pick_exclude),
    .found   (pick_found),
    .index   (pick_index),
    .onehot  (pick_onehot)
  );

  logic                 owner_req;
  logic                 owner_lock;
  logic                 others_pending;
  logic                 hold_expired;
  logic [CNT_WIDTH-1:0] hold_cnt_inc;

  assign owner_req      = req[sel_reg];
  assign owner_lock     = lock[sel_reg];
  assign others_pending = |(req & ~grant_reg);
  // Expiry is judged on the count before this edge's increment, so an owner
  // keeps the bus for exactly MAX_HOLD cycles under contention.
  assign hold_expired   = (hold_cnt_reg >= CNT_WIDTH'(MAX_HOLD - 1));
  assign hold_cnt_inc   = (hold_cnt_reg == CNT_WIDTH'(MAX_HOLD)) ? hold_cnt_reg
                                                                : hold_cnt_reg + CNT_WIDTH'(1);

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    sel_next      = sel_reg;
    preempt_next  = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        grant_next = '0;
        if (pick_found) begin
          state_next    = ARB_GRANT;
          grant_next    = pick_onehot;
          sel_next      = pick_index;
          hold_cnt_next = '0;
        end
      end

      ARB_GRANT, ARB_LOCKED: begin
        hold_cnt_next = hold_cnt_inc;
        if (!owner_req) begin
          // Release wins over expiry and lock; hand off without a bubble
          // when someone else is waiting.
          rr_ptr_next   = sel_reg + SEL_WIDTH'(1);
          hold_cnt_next = '0;
          if (pick_found) begin
            state_next = ARB_GRANT;
            grant_next = pick_onehot;
            sel_next   = pick_index;
          end else begin
            state_next = ARB_IDLE;
            grant_next = '0;
          end
        end else if (state_reg == ARB_LOCKED) begin
          if (!owner_lock) begin
            state_next = ARB_GRANT;
          end
        end else if (owner_lock) begin
          state_next = ARB_LOCKED;
        end else if (hold_expired && others_pending) begin
          // others_pending guarantees pick_found here.
          state_next    = ARB_GRANT;
          rr_ptr_next   = sel_reg + SEL_WIDTH'(1);
          hold_cnt_next = '0;
          grant_next    = pick_onehot;
          sel_next      = pick_index;
          preempt_next  = 1'b1;
        end
      end

      default: begin
        state_next    = ARB_IDLE;
        grant_next    = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ARB_IDLE;
      rr_ptr_reg    <= '0;
      hold_cnt_reg  <= '0;
      grant_reg     <= '0;
      sel_reg       <= '0;
      bus_valid_reg <= 1'b0;
      preempt_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      grant_reg     <= grant_next;
      sel_reg       <= sel_next;
      bus_valid_reg <= (state_next != ARB_IDLE);
      preempt_reg   <= preempt_next;
    end
  end

  assign grant     = grant_reg;
  assign sel       = sel_reg;
  assign bus_valid = bus_valid_reg;
  assign preempt   = preempt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed and randomized stimulus for bus_arbiter (SIZE=4, MAX_HOLD=4),
//   checked each cycle against a behavioural model of the arbitration rules.
module tb_bus_arbiter;

  localparam int SIZE     = 4;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       bus_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(
    .SIZE     (SIZE),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the bus, for how long, whether locked.
  int m_owner;   // -1 when nobody owns the bus
  int m_age;     // cycles of ownership so far, saturating at MAX_HOLD
  int m_ptr;     // round-robin start point used when idle
  int m_sel;     // last owner index shown on sel
  bit m_locked;
  bit m_pre;
  int preempt_seen;

  function automatic int pick_next(int start, int skip, logic [3:0] r);
    for (int k = 0; k < SIZE; k++) begin
      int i;
      i = (start + k) % SIZE;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0; m_locked = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l);
    int prev_age;
    logic [3:0] others;
    m_pre = 0;
    if (m_owner < 0) begin
      m_owner = pick_next(m_ptr, -1, r);
      m_age = 0;
      m_locked = 0;
    end else begin
      prev_age = m_age;
      m_age = (m_age < MAX_HOLD) ? m_age + 1 : MAX_HOLD;
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % SIZE;
        m_owner = pick_next(m_ptr, m_owner, r);
        m_age = 0;
        m_locked = 0;
      end else if (m_locked) begin
        if (!l[m_owner]) m_locked = 0;
      end else if (l[m_owner]) begin
        m_locked = 1;
      end else if (prev_age >= MAX_HOLD - 1 && others != 4'b0000) begin
        m_ptr = (m_owner + 1) % SIZE;
        m_owner = pick_next(m_ptr, m_owner, r);
        m_age = 0;
        m_pre = 1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_grant;
    exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    checks++;
    assert (grant === exp_grant) else begin
      errors++;
      $error("FAIL %s grant: got %b expected %b", tag, grant, exp_grant);
    end
    checks++;
    assert (sel === 2'(m_sel)) else begin
      errors++;
      $error("FAIL %s sel: got %0d expected %0d", tag, sel, m_sel);
    end
    checks++;
    assert (bus_valid === (m_owner >= 0)) else begin
      errors++;
      $error("FAIL %s bus_valid: got %b expected %b", tag, bus_valid, (m_owner >= 0));
    end
    checks++;
    assert (preempt === m_pre) else begin
      errors++;
      $error("FAIL %s preempt: got %b expected %b", tag, preempt, m_pre);
    end
    if (preempt === 1'b1) preempt_seen++;
  endtask

  // Direct check of an output against a value stated by the test plan.
  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives inputs, advances one edge, checks at posedge+1.
  task automatic cycle(input string tag, input logic [3:0] r, input logic [3:0] l);
    req = r;
    lock = l;
    @(posedge clk);
    model_step(r, l);
    #1;
    check_outputs(tag);
    $display("%s: req=%b lock=%b -> grant=%b sel=%0d valid=%b preempt=%b",
             tag, r, l, grant, sel, bus_valid, preempt);
  endtask

  // Asserts reset between clock edges and checks it acts without an edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] l;
    req = 4'b0000;
    lock = 4'b0000;
    reset_n = 1'b0;
    preempt_seen = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("por");
    reset_n = 1'b1;

    // Single request, then release: sel must keep its last value.
    cycle("single", 4'b0100, 4'b0000);
    check_val("single_grant", grant, 4'b0100);
    for (int i = 0; i < 3; i++) cycle("single_hold", 4'b0100, 4'b0000);
    cycle("single_rel", 4'b0000, 4'b0000);
    check_val("single_rel_sel", {2'b00, sel}, 4'd2);
    check_val("single_rel_grant", grant, 4'b0000);

    // Asynchronous reset while master 2 owns the bus.
    cycle("pre_rst", 4'b0100, 4'b0000);
    check_val("pre_rst_grant", grant, 4'b0100);
    do_reset();
    check_val("rst_grant", grant, 4'b0000);
    for (int i = 0; i < 3; i++) cycle("idle_after_rst", 4'b0000, 4'b0000);

    // Rotation under full load: 4-cycle tenures, one preempt per handoff.
    preempt_seen = 0;
    cycle("rot", 4'b1111, 4'b0000);
    check_val("rot_first", grant, 4'b0001);
    for (int i = 0; i < 16; i++) cycle("rot", 4'b1111, 4'b0000);
    check_val("rot_wrap", grant, 4'b0001);
    check_val("rot_preempts", 4'(preempt_seen), 4'd4);

    // Direct handoff on release with no idle bubble.
    do_reset();
    cycle("handoff_own1", 4'b0010, 4'b0000);
    cycle("handoff", 4'b1001, 4'b0000);
    check_val("handoff_grant", grant, 4'b1000);
    check_val("handoff_sel", {2'b00, sel}, 4'd3);
    check_val("handoff_preempt", {3'b000, preempt}, 4'd0);

    // Lock holds off preemption; unlocking lets the handoff through.
    do_reset();
    preempt_seen = 0;
    for (int i = 0; i < 12; i++) cycle("locked", 4'b0011, 4'b0001);
    check_val("locked_grant", grant, 4'b0001);
    check_val("locked_no_preempt", 4'(preempt_seen), 4'd0);
    for (int i = 0; i < 3; i++) cycle("unlock", 4'b0011, 4'b0000);
    check_val("unlock_grant", grant, 4'b0010);
    check_val("unlock_preempts", 4'(preempt_seen), 4'd1);

    // Release coinciding with hold expiry is a plain release.
    do_reset();
    for (int i = 0; i < 4; i++) cycle("expiry_own0", 4'b0001, 4'b0000);
    cycle("coincide", 4'b0010, 4'b0000);
    check_val("coincide_grant", grant, 4'b0010);
    check_val("coincide_preempt", {3'b000, preempt}, 4'd0);
    cycle("coincide_rel", 4'b0000, 4'b0000);
    cycle("ptr_check", 4'b0011, 4'b0000);

    // Randomized traffic with sticky requests and occasional locks.
    r = 4'b0000;
    l = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 30) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 15) l = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      cycle("rand", r, l);
      if (i == 200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
